wrr_arbiter: RTL and testbench
==============================

// Module: wrr_arbiter
// PURPOSE
//  Parametrised weighted round-robin arbiter: N requesters, per-channel programmable
//  max-tenure quota, optional tenure lock. Registered one-hot grant. Next generation
//  of the fixed 4-way, 4-cycle-tenure round-robin FSM arbiter; used in front of
//  shared buses/memories.
// PARAMETERS
//  N      4  number of requesters (>=2)
//  WW     3  width of each per-channel weight field
//  IDW    $clog2(N)  width of grant_id (localparam, not overridable)
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous, active-low reset
//  req        in   N     request vector, bit i = requester i; level, held until served
//  weight     in   N*WW  weight[i*WW +: WW] = max consecutive grant cycles of ch i; 0 = ch disabled
//  lock       in   1     1: current owner keeps grant past quota while its req stays high
//  grant      out  N     registered one-hot grant, or all-zero when idle
//  grant_id   out  IDW   index of current/last owner
//  grant_vld  out  1     1 when grant != 0
//  rearb      out  1     1-cycle pulse: grant changed owner or went idle->busy this cycle
// BEHAVIOUR
//  - Reset (async, immediate, no clock needed): grant=0, grant_vld=0, grant_id=N-1,
//    rearb=0, tenure cnt=0, state=IDLE. First search after reset therefore starts at ch0.
//  - Eligible(i) = req[i] & (weight[i]!=0). Weights and lock sampled live each cycle.
//  - FSM: IDLE (grant_vld=0), BUSY (grant_vld=1, owner=grant_id). All decisions
//    registered: grant visible one cycle after the edge on which req is sampled.
//  - IDLE: any eligible -> BUSY, owner = first eligible searching grant_id+1, +2, ...
//    modulo N; cnt=1; rearb=1. None eligible -> stay IDLE, grant_id unchanged.
//  - BUSY, owner not eligible (req dropped or weight->0): re-search from owner+1;
//    hit -> new owner, cnt=1, rearb=1; miss -> IDLE, grant=0, grant_id kept, rearb=1.
//  - BUSY, owner eligible, cnt<weight[owner]: hold, cnt++ , rearb=0.
//  - BUSY, owner eligible, cnt>=weight[owner]:
//      lock=1 -> hold, cnt saturates at 2^WW-1, rearb=0;
//      lock=0 -> search from owner+1 excluding owner; hit -> new owner, cnt=1, rearb=1;
//               miss -> owner keeps grant, cnt restarts at 1, rearb=0.
//  - Tenure length: owner holds exactly weight[owner] cycles when others pending and
//    lock=0. Weight lowered below cnt mid-tenure: quota treated as expired next edge.
//  - Wrap-around: search index computed modulo N; owner N-1 searches from 0.
//  - At most one grant bit high in any cycle; grant never asserted to ineligible ch
//    in the cycle its req was sampled low.
//  - cnt width WW; never wraps (saturating).
// STRUCTURE
//  - Package wrr_arb_pkg: state enum {ARB_IDLE, ARB_BUSY}; function rotate-find-first
//    (vector, start index, N) returning {found, index}.
//  - One sub-module: wrr_prio_pick (combinational): inputs eligible mask, start
//    pointer, exclude-owner flag; outputs found, index. Top holds FSM, cnt, grant regs.
// TESTING (N=4, WW=3)
//  1. rst_n=0 with req=4'b1111 -> grant=0, grant_vld=0, grant_id=3; release, req=0
//     for 5 cycles -> grant stays 0, rearb never pulses.
//  2. req=4'b1111, all weights=4, lock=0 -> grant 0001 x4, 0010 x4, 0100 x4, 1000 x4,
//     0001 again; first grant 1 cycle after req; rearb pulses at each change.
//  3. req=4'b0001 only, weight0=2 -> grant 0001 continuous, cnt cycles 1,2,1,2; rearb
//     once only at start.
//  4. Owner ch1 (grant 0010) drops req, req=4'b1001 -> next cycle grant 1000 (search
//     from ch2), rearb=1; then ch3 drops with req=0 -> grant 0, grant_id=3.
//  5. weight2=0, req=4'b0100 -> grant stays 0; weight1=1, lock=1, req=4'b0110 ->
//     grant 0010 held 10 cycles, cnt saturates at 7; lock=0 -> ch2 still masked,
//     grant remains 0010.
//  6. rst_n asserted mid-tenure (grant 0100, cnt=2) between clock edges -> grant=0
//     immediately; release with req=4'b1111 -> first grant 0001.

Source files
------------

// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package wrr_arb_pkg;

  // Arbiter control state: IDLE has no owner, BUSY has a live grant.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // The search helper works on a fixed-width vector so it can be shared by
  // every arbiter size up to this many requesters.
  localparam int unsigned PICK_MAX_N = 64;
  localparam int unsigned PICK_IDX_W = 6;

  // Result of a rotating search.
  typedef struct packed {
    logic                  found;
    logic [PICK_IDX_W-1:0] idx;
  } pick_t;

  // Return the first set bit of vec[n-1:0], visiting start, start+1, ...
  // and wrapping modulo n. start must already be in the range [0, n).
  function automatic pick_t rot_find_first(
    input logic [PICK_MAX_N-1:0] vec,
    input int unsigned           start,
    input int unsigned           n
  );
    pick_t       res;
    int unsigned pos;
    res = '0;
    for (int unsigned k = 0; k < PICK_MAX_N; k++) begin
      if (k < n) begin
        pos = start + k;
        if (pos >= n) begin
          pos = pos - n;
        end
        if (!res.found && vec[pos[PICK_IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = pos[PICK_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wrr_prio_pick.sv
// Rotating priority picker: first eligible requester strictly after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is only a candidate, the caller decides whether to take it.
module wrr_prio_pick
  import wrr_arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   elig,
  input  logic [IDW-1:0] ptr,
  input  logic           excl,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [PICK_MAX_N-1:0] vec;
  int unsigned           start;
  pick_t                 pick;

  // Mask the current owner when asked, then search from the slot after ptr.
  // Searching without exclusion still reaches ptr last, so an idle arbiter
  // can re-grant the previous owner when it is the only one asking.
  always_comb begin
    vec         = '0;
    vec[N-1:0]  = elig;
    if (excl) begin
      vec[ptr] = 1'b0;
    end
    start = 32'(ptr) + 32'd1;
    if (start >= 32'(N)) begin
      start = 32'd0;
    end
    pick  = rot_find_first(vec, start, 32'(N));
    found = pick.found;
    idx   = IDW'(pick.idx);
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: N requesters, per-channel tenure quota, optional lock.
// Latency: grant is registered, visible one cycle after the edge that samples req.
// Backpressure: requesters hold req until granted; ineligible (req low or weight 0) channels are skipped.
module wrr_arbiter
  import wrr_arb_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int WW  = 3,
  localparam int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            lock,
  output logic [N-1:0]    grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_vld,
  output logic            rearb
);

  localparam logic [WW-1:0] CNT_MAX = {WW{1'b1}};
  localparam logic [WW-1:0] CNT_ONE = WW'(1);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] id_q,    id_d;
  logic [WW-1:0]  cnt_q,   cnt_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           rearb_q, rearb_d;

  logic [N-1:0]   elig;
  logic [WW-1:0]  w_own;
  logic           own_elig;
  logic           excl;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;

  // A channel competes only while it requests and has a non-zero quota.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = req[i] & (|weight[i*WW +: WW]);
    end
  end

  // Live quota of the current owner; weights are not latched at grant time.
  always_comb begin
    w_own = '0;
    for (int i = 0; i < N; i++) begin
      if (id_q == IDW'(i)) begin
        w_own = weight[i*WW +: WW];
      end
    end
  end

  assign own_elig = elig[id_q];

  // Exclude the owner only when it is still eligible, i.e. its quota ran out
  // and we are looking for someone else to hand over to.
  assign excl = (state_q == ARB_BUSY) && own_elig;

  wrr_prio_pick #(
    .N (N)
  ) u_pick (
    .elig  (elig),
    .ptr   (id_q),
    .excl  (excl),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state, tenure counter and rearbitration pulse.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    rearb_d = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_BUSY;
          id_d    = pick_idx;
          cnt_d   = CNT_ONE;
          rearb_d = 1'b1;
        end
      end

      ARB_BUSY: begin
        if (!own_elig) begin
          // Owner left (req dropped or weight zeroed): hand over or go idle.
          rearb_d = 1'b1;
          if (pick_found) begin
            id_d  = pick_idx;
            cnt_d = CNT_ONE;
          end else begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
          end
        end else if (cnt_q < w_own) begin
          // Still inside the quota.
          cnt_d = cnt_q + 1'b1;
        end else if (lock) begin
          // Quota spent but locked: keep the bus, count up without wrapping.
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (pick_found) begin
          // Quota spent, someone else waiting: rotate.
          id_d    = pick_idx;
          cnt_d   = CNT_ONE;
          rearb_d = 1'b1;
        end else begin
          // Quota spent, nobody else waiting: owner starts a fresh tenure.
          cnt_d = CNT_ONE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One-hot grant derived from the next owner so it lines up with state.
  always_comb begin
    grant_d = '0;
    for (int i = 0; i < N; i++) begin
      grant_d[i] = (state_d == ARB_BUSY) && (id_d == IDW'(i));
    end
  end

  // Arbiter state registers; reset leaves grant_id at N-1 so the first
  // search after reset starts at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      id_q    <= IDW'(N - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      rearb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      rearb_q <= rearb_d;
    end
  end

  assign grant     = grant_q;
  assign grant_id  = id_q;
  assign grant_vld = (state_q == ARB_BUSY);
  assign rearb     = rearb_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter (N=4, WW=3): directed scenarios plus random traffic.
// Latency: a reference model is advanced once per clock and compared one cycle later.
// Backpressure: n/a.
module tb_wrr_arbiter;

  localparam int N   = 4;
  localparam int WW  = 3;
  localparam int CMX = (1 << WW) - 1;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req   = '0;
  logic [N*WW-1:0] weight = '0;
  logic            lock  = 1'b0;
  logic [N-1:0]    grant;
  logic [1:0]      grant_id;
  logic            grant_vld;
  logic            rearb;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: who owns the bus and how long it has held it.
  int m_busy;
  int m_own;
  int m_cnt;
  int m_rearb;

  wrr_arbiter #(.N(N), .WW(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .weight    (weight),
    .lock      (lock),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld),
    .rearb     (rearb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wt(input int ch);
    return int'(weight[ch*WW +: WW]);
  endfunction

  task automatic set_w(input int ch, input int v);
    weight[ch*WW +: WW] = WW'(v);
  endtask

  // First requester with a non-zero weight after 'from', going round the ring.
  function automatic int search(input int from, input bit skip_from);
    int i;
    for (int k = 1; k <= N; k++) begin
      i = (from + k) % N;
      if (skip_from && i == from) continue;
      if (req[i] && wt(i) != 0) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_own   = N - 1;
    m_cnt   = 0;
    m_rearb = 0;
  endtask

  // One clock of arbitration decided from the inputs currently applied.
  task automatic model_step();
    int hit;
    bit oe;
    m_rearb = 0;
    if (m_busy == 0) begin
      hit = search(m_own, 1'b0);
      if (hit >= 0) begin
        m_busy = 1; m_own = hit; m_cnt = 1; m_rearb = 1;
      end
    end else begin
      oe = req[m_own] && (wt(m_own) != 0);
      if (!oe) begin
        hit     = search(m_own, 1'b0);
        m_rearb = 1;
        if (hit >= 0) begin
          m_own = hit; m_cnt = 1;
        end else begin
          m_busy = 0; m_cnt = 0;
        end
      end else if (m_cnt < wt(m_own)) begin
        m_cnt++;
      end else if (lock) begin
        m_cnt = (m_cnt + 1 > CMX) ? CMX : m_cnt + 1;
      end else begin
        hit = search(m_own, 1'b1);
        if (hit >= 0) begin
          m_own = hit; m_cnt = 1; m_rearb = 1;
        end else begin
          m_cnt = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_val("mdl.grant",     32'(grant),     m_busy != 0 ? (32'd1 << m_own) : 32'd0);
    check_val("mdl.grant_id",  32'(grant_id),  32'(m_own));
    check_val("mdl.grant_vld", 32'(grant_vld), 32'(m_busy));
    check_val("mdl.rearb",     32'(rearb),     32'(m_rearb));
    check_val("mdl.cnt",       32'(dut.cnt_q), 32'(m_cnt));
  endtask

  // Inputs are stable from just after the previous edge; the model decides at
  // the falling edge and the DUT is checked just after the next rising edge.
  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) set_w(i, 4);

    // 1: asynchronous reset with all requests high, then idle cycles
    req = 4'b1111;
    #1 rst_n = 1'b0;
    #2;
    check_val("t1.grant",     32'(grant),     32'd0);
    check_val("t1.grant_vld", 32'(grant_vld), 32'd0);
    check_val("t1.grant_id",  32'(grant_id),  32'd3);
    check_val("t1.rearb",     32'(rearb),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step();
      check_val("t1.idle_grant", 32'(grant), 32'd0);
      check_val("t1.idle_rearb", 32'(rearb), 32'd0);
    end

    // 2: all requesting, weight 4 each -> four-cycle tenures in ring order
    req = 4'b1111;
    step();
    check_val("t2.first", 32'(grant), 32'd1);
    for (int c = 1; c <= 16; c++) begin
      step();
      check_val("t2.seq",   32'(grant), 32'd1 << ((c / 4) % 4));
      check_val("t2.rearb", 32'(rearb), (c % 4 == 0) ? 32'd1 : 32'd0);
    end

    // 4: owner ch1 drops, ch0/ch3 pending -> search from ch2 lands on ch3
    for (int k = 0; k < 8 && grant != 4'b0010; k++) step();
    check_val("t4.reach_ch1", 32'(grant), 32'd2);
    req = 4'b1001;
    step();
    check_val("t4.grant_ch3", 32'(grant), 32'd8);
    check_val("t4.rearb",     32'(rearb), 32'd1);
    req = 4'b0000;
    step();
    check_val("t4.idle",     32'(grant),    32'd0);
    check_val("t4.idle_id",  32'(grant_id), 32'd3);
    check_val("t4.idle_rrb", 32'(rearb),    32'd1);

    // 3: lone requester with weight 2 keeps the grant, tenure count 1,2,1,2
    set_w(0, 2);
    req = 4'b0001;
    step();
    check_val("t3.grant", 32'(grant),     32'd1);
    check_val("t3.rearb", 32'(rearb),     32'd1);
    check_val("t3.cnt",   32'(dut.cnt_q), 32'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      check_val("t3.hold",  32'(grant),     32'd1);
      check_val("t3.norrb", 32'(rearb),     32'd0);
      check_val("t3.cnt",   32'(dut.cnt_q), (k % 2 == 0) ? 32'd2 : 32'd1);
    end

    // 5: disabled channel never granted; lock holds past quota and saturates
    set_w(2, 0);
    req = 4'b0100;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("t5.masked", 32'(grant), 32'd0);
    end
    set_w(1, 1);
    lock = 1'b1;
    req  = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      step();
      check_val("t5.locked", 32'(grant), 32'd2);
    end
    check_val("t5.sat", 32'(dut.cnt_q), 32'd7);
    lock = 1'b0;
    step();
    check_val("t5.unlock",     32'(grant),     32'd2);
    check_val("t5.unlock_cnt", 32'(dut.cnt_q), 32'd1);

    // 6: reset asserted between edges mid-tenure clears the grant at once
    for (int i = 0; i < N; i++) set_w(i, 4);
    req = 4'b0100;
    step();
    step();
    check_val("t6.pre_grant", 32'(grant),     32'd4);
    check_val("t6.pre_cnt",   32'(dut.cnt_q), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("t6.rst_grant", 32'(grant),     32'd0);
    check_val("t6.rst_vld",   32'(grant_vld), 32'd0);
    check_val("t6.rst_id",    32'(grant_id),  32'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b1111;
    step();
    check_val("t6.first", 32'(grant), 32'd1);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) set_w(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) == 0) lock = ~lock;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
